// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the bit-addressable data memory.
package cpu_pkg;

  // Address width of the bit RAM; depth is 2**BIT_RAM_AWIDTH cells.
  localparam int BIT_RAM_AWIDTH = 8;

  typedef logic [BIT_RAM_AWIDTH-1:0] bit_addr_t;

  // Number of cells addressed by an address of the given width.
  function automatic int unsigned bit_ram_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ram_bit_3port_if.sv
// Port bundle of the bit RAM: two combinational read ports and one clocked write port.
interface ram_bit_3port_if
  import cpu_pkg::*;
#(
  parameter int AWIDTH = BIT_RAM_AWIDTH
);

  logic [AWIDTH-1:0] port_a_address;
  logic              port_a_out;
  logic [AWIDTH-1:0] port_b_address;
  logic              port_b_out;
  logic [AWIDTH-1:0] port_c_address;
  logic              port_c_data;
  logic              port_c_we;

  // The CPU side drives addresses and write data and consumes the read bits.
  modport master (
    output port_a_address,
    input  port_a_out,
    output port_b_address,
    input  port_b_out,
    output port_c_address,
    output port_c_data,
    output port_c_we
  );

  // The memory side answers reads and accepts writes.
  modport slave (
    input  port_a_address,
    output port_a_out,
    input  port_b_address,
    output port_b_out,
    input  port_c_address,
    input  port_c_data,
    input  port_c_we
  );

endinterface

// File: rtl/ram_bit_3port_wdec.sv
// One-hot write decoder: turns the write address and enable into per-cell write strobes.
module ram_bit_wdec
  import cpu_pkg::*;
#(
  parameter int AWIDTH = BIT_RAM_AWIDTH,
  parameter int DEPTH  = 2 ** AWIDTH
) (
  input  logic [AWIDTH-1:0] addr_i,
  input  logic              we_i,
  output logic [DEPTH-1:0]  wen_o
);

  // Raise exactly one strobe when writing, none otherwise.
  always_comb begin
    wen_o = '0;
    if (we_i) begin
      wen_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_bit_3port.sv
// Bit-addressable data memory: one flop per bit cell, two asynchronous read
// ports feeding the logic unit operands and one synchronous write-back port.
module ram_bit_3port
  import cpu_pkg::*;
#(
  parameter int AWIDTH = BIT_RAM_AWIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_bit_3port_if.slave  bus
);

  localparam int DEPTH = int'(bit_ram_depth(AWIDTH));

  logic [DEPTH-1:0] writeEn;
  logic [DEPTH-1:0] cellBits;

  ram_bit_wdec #(
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_wdec (
    .addr_i (bus.port_c_address),
    .we_i   (bus.port_c_we),
    .wen_o  (writeEn)
  );

  // Each cell is its own flop so the async clear empties the whole array at once
  // and a write touches only the strobed cell.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic cell_q;
    logic cell_d;

    // Hold the stored bit unless this cell is the write target.
    always_comb begin
      cell_d = cell_q;
      if (writeEn[i]) begin
        cell_d = bus.port_c_data;
      end
    end

    // Cell storage; reset dominates so writes are ignored while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cell_q <= 1'b0;
      end else begin
        cell_q <= cell_d;
      end
    end

    assign cellBits[i] = cell_q;
  end

  // Reads come straight from the flops with no bypass of port_c_data, so a
  // read of the cell being written shows the old bit until the clock edge and
  // write data derived from a read output cannot form a combinational loop.
  assign bus.port_a_out = cellBits[bus.port_a_address];
  assign bus.port_b_out = cellBits[bus.port_b_address];

endmodule

// File: tb/tb_ram_bit_3port.sv
// Scoreboard bench for the bit RAM: stimulus pushes expected read bits, a
// monitor on the falling edge pops and compares them against the read ports.
module tb_ram_bit_3port;
  import cpu_pkg::*;

  typedef struct {
    string     name;
    bit_addr_t addrA;
    bit_addr_t addrB;
    logic      expA;
    logic      expB;
  } exp_t;

  logic clk;
  logic rst_n;
  logic dataDrv;
  logic fbMode;

  exp_t sbQ[$];
  logic model [0:255];

  int total;
  int bad;

  ram_bit_3port_if #(.AWIDTH(BIT_RAM_AWIDTH)) ifc ();

  ram_bit_3port #(.AWIDTH(BIT_RAM_AWIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Write data is either a plain value or the inverse of port A, which
  // exercises the read-modify-write feedback path through the memory.
  assign ifc.port_c_data = fbMode ? ~ifc.port_a_out : dataDrv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one queued expectation against both read ports.
  task automatic checkOutput(input exp_t e);
    total++;
    if (ifc.port_a_out !== e.expA) begin
      bad++;
      $display("[TB] FAIL %s portA addr=%0d got=%b want=%b", e.name, e.addrA, ifc.port_a_out, e.expA);
    end
    total++;
    if (ifc.port_b_out !== e.expB) begin
      bad++;
      $display("[TB] FAIL %s portB addr=%0d got=%b want=%b", e.name, e.addrB, ifc.port_b_out, e.expB);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a pending
  // expectation is sampled half a period after the inputs settled.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      checkOutput(sbQ.pop_front());
    end
  end

  // Drive one cycle of inputs, queue the expected reads for this cycle, then
  // record the write that will land at the next rising edge.
  task automatic applyStimulus(input string name, input bit_addr_t a, input bit_addr_t b,
                               input bit_addr_t c, input logic d, input logic we, input logic fb);
    exp_t e;
    @(posedge clk);
    #1;
    ifc.port_a_address = a;
    ifc.port_b_address = b;
    ifc.port_c_address = c;
    dataDrv            = d;
    fbMode             = fb;
    ifc.port_c_we      = we;
    e.name  = name;
    e.addrA = a;
    e.addrB = b;
    e.expA  = model[a];
    e.expB  = model[b];
    sbQ.push_back(e);
    if (we && rst_n) begin
      model[c] = fb ? ~model[a] : d;
    end
  endtask

  // Assert reset between clock edges and expect the outputs to clear at once.
  task automatic pulseReset(input bit_addr_t a, input bit_addr_t b);
    exp_t e;
    @(posedge clk);
    #1;
    ifc.port_a_address = a;
    ifc.port_b_address = b;
    ifc.port_c_we      = 1'b0;
    fbMode             = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 1'b0;
    e.name  = "rst_async";
    e.addrA = a;
    e.addrB = b;
    e.expA  = 1'b0;
    e.expB  = 1'b0;
    sbQ.push_back(e);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    ifc.port_c_we = 1'b0;
    rst_n         = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    dataDrv = 1'b0;
    fbMode  = 1'b0;
    ifc.port_a_address = '0;
    ifc.port_b_address = '0;
    ifc.port_c_address = '0;
    ifc.port_c_we      = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 1'b0;

    // Power-on reset, including a write attempt that must be ignored.
    applyStimulus("por_read", 8'd0, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("por_write_ignored", 8'd0, 8'd1, 8'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus("por_after_write", 8'd0, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0);
    releaseReset();

    // Fill: mem[0]=1, mem[i]=~i[0]; one write pulse every second cycle.
    for (int i = 0; i < 256; i++) begin
      bit_addr_t ai;
      logic      di;
      ai = bit_addr_t'(i);
      di = (i == 0) ? 1'b1 : ~ai[0];
      applyStimulus("fill_write", ai, bit_addr_t'(i == 0 ? 0 : i - 1), ai, di, 1'b1, 1'b0);
      applyStimulus("fill_idle", ai, ai, ai, ~di, 1'b0, 1'b0);
    end

    // Readback sweeps, A then B.
    for (int i = 0; i < 256; i++)
      applyStimulus("sweep_a", bit_addr_t'(i), 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++)
      applyStimulus("sweep_b", 8'd0, bit_addr_t'(i), 8'd0, 1'b0, 1'b0, 1'b0);

    // Dual reads at opposite ends, then at the same address.
    for (int i = 1; i < 256; i++)
      applyStimulus("dual_diff", bit_addr_t'(i), bit_addr_t'(256 - i), 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++)
      applyStimulus("dual_same", bit_addr_t'(i), bit_addr_t'(i), 8'd0, 1'b0, 1'b0, 1'b0);

    // Write enable low must leave mem[5] untouched; one enabled edge flips it.
    for (int k = 0; k < 3; k++)
      applyStimulus("we_low", 8'd5, 8'd5, 8'd5, ~model[5], 1'b0, 1'b0);
    applyStimulus("we_high", 8'd5, 8'd5, 8'd5, ~model[5], 1'b1, 1'b0);
    applyStimulus("we_flipped", 8'd5, 8'd4, 8'd5, 1'b0, 1'b0, 1'b0);

    // Read-during-write at 0x10 with feedback data; B watches the neighbour.
    applyStimulus("rdw_before", 8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 1'b1);
    applyStimulus("rdw_after", 8'h10, 8'h11, 8'h10, 1'b0, 1'b0, 1'b1);
    applyStimulus("rdw_settled", 8'h10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0);

    // Toggle sweep: invert each cell 2..255 in place through port A feedback.
    for (int i = 2; i < 256; i++) begin
      applyStimulus("toggle_write", bit_addr_t'(i), bit_addr_t'(i), bit_addr_t'(i), 1'b0, 1'b1, 1'b1);
      applyStimulus("toggle_idle", bit_addr_t'(i), bit_addr_t'(i), bit_addr_t'(i), 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 256; i++)
      applyStimulus("toggle_verify", 8'd0, bit_addr_t'(i), 8'd0, 1'b0, 1'b0, 1'b0);

    // Mid-sequence reset after writes: mem[0] and mem[3] hold 1 here.
    pulseReset(8'd0, 8'd3);
    for (int i = 0; i < 256; i++)
      applyStimulus("rst_sweep", bit_addr_t'(i), bit_addr_t'(255 - i), bit_addr_t'(i), 1'b1, 1'b1, 1'b0);
    releaseReset();

    // Writes resume once reset is released.
    applyStimulus("post_rst_write", 8'h20, 8'h21, 8'h20, 1'b1, 1'b1, 1'b0);
    applyStimulus("post_rst_read", 8'h20, 8'h21, 8'h20, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int k = 0; k < 10 && sbQ.size() > 0; k++) @(negedge clk);
    #1;
    total++;
    if (sbQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", sbQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
